fsm_sequence_detector: RTL and testbench

Mealy-type serial bit-pattern detector, one bit per clock, default pattern 1011 (first-received bit is the MSB). The output asserts combinationally in the same cycle the final pattern bit is present on the input. It sits on a serial data path as a framing/sync-word flag generator. Overlapping detection is the default and can be configured off.

---
 rtl/fsm_sequence_detector.sv | 115 +++++++++++
 tb/tb_fsm_sequence_detector.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fsm_sequence_detector.sv
// fsm_sequence_detector
//
// Mealy serial bit-pattern detector. One bit is consumed on every rising edge
// of clk_c. The state is the length of the longest prefix of PATTERN that
// matches the most recently received bits (0..PATTERN_W-1). q_o flags
// combinationally while the final pattern bit is on in_i, so there is no
// latency between the last bit being presented and the flag.
//
// Handshake: none. Every clock cycle consumes exactly one bit from in_i and
// there is no valid qualifier.
//
// Parameters:
//   PATTERN_W : pattern length in bits (2..16)
//   PATTERN   : pattern to detect, MSB is the first bit received
//   OVERLAP   : 1 = overlapping matches allowed, 0 = restart empty after a match
//
// Ports:
//   clk_c   : clock, all state updates on the rising edge
//   reset_r : synchronous, active-high reset (state -> empty, q_o forced low)
//   in_i    : serial data bit
//   q_o     : match flag, combinational from state and in_i
module fsm_sequence_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic clk_c,
  input  logic reset_r,
  input  logic in_i,
  output logic q_o
);

  localparam int SW = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
  localparam int NS = 1 << SW;

  // State encoding is binary match length; unreachable codes (when PATTERN_W
  // is not a power of two) map back to the empty state.
  typedef logic [SW-1:0] state_t;

  localparam state_t S_EMPTY = '0;
  localparam state_t S_LAST  = state_t'(PATTERN_W - 1);

  // Bit i of a 17-bit vector, tolerant of any integer index.
  function automatic logic bit_at(input logic [16:0] v, input int i);
    logic [16:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Next match length after being in state k and receiving bit b. This is the
  // KMP transition worked out directly: find the longest pattern prefix that
  // is a suffix of (matched prefix of length k, then b). A full match is
  // capped at PATTERN_W-1, which yields the longest proper border when
  // overlapping; without overlap a full match returns to empty.
  function automatic int next_state(input int k, input int b);
    logic [16:0] pat;
    logic [16:0] s;
    int          lim;
    int          best;
    logic        ok;
    pat  = 17'(PATTERN);
    s    = '0;
    best = 0;
    if (k >= PATTERN_W) return 0;
    if (!OVERLAP && (k == PATTERN_W - 1) && (b[0] == PATTERN[0])) return 0;
    for (int j = 0; j < 16; j++) begin
      if (j < k) s = s | (17'(bit_at(pat, PATTERN_W - 1 - j)) << j);
    end
    s   = s | (17'(b[0]) << k);
    lim = (k + 1 < PATTERN_W) ? k + 1 : PATTERN_W - 1;
    for (int l = 1; l <= 16; l++) begin
      if (l <= lim) begin
        ok = 1'b1;
        for (int m = 0; m < 16; m++) begin
          if ((m < l) && (bit_at(s, k + 1 - l + m) != bit_at(pat, PATTERN_W - 1 - m)))
            ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Transition tables, fixed at elaboration.
  state_t next_on0 [NS];
  state_t next_on1 [NS];

  for (genvar g = 0; g < NS; g++) begin : g_tbl
    assign next_on0[g] = state_t'(next_state(g, 0));
    assign next_on1[g] = state_t'(next_state(g, 1));
  end

  state_t state_q;
  state_t state_d;
  logic   q_d;

  always_comb begin
    state_d = state_q;
    q_d     = 1'b0;
    state_d = in_i ? next_on1[state_q] : next_on0[state_q];
    // Reset gates the flag so q_o is defined even before the first reset edge.
    q_d     = (state_q == S_LAST) && (in_i == PATTERN[0]) && !reset_r;
  end

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = q_d;

endmodule

// File: tb/tb_fsm_sequence_detector.sv
module tb_fsm_sequence_detector;

  // ---------------- clock / reset ----------------
  logic clk_c = 1'b0;
  logic reset_r;
  logic in_i;
  logic q_a, q_b, q_c;

  always #5 clk_c = ~clk_c;

  // a: default 1011 overlap, b: 1011 no overlap, c: 11011 overlap
  fsm_sequence_detector dut_a (
    .clk_c(clk_c), .reset_r(reset_r), .in_i(in_i), .q_o(q_a)
  );
  fsm_sequence_detector #(.OVERLAP(1'b0)) dut_b (
    .clk_c(clk_c), .reset_r(reset_r), .in_i(in_i), .q_o(q_b)
  );
  fsm_sequence_detector #(.PATTERN_W(5), .PATTERN(5'b11011)) dut_c (
    .clk_c(clk_c), .reset_r(reset_r), .in_i(in_i), .q_o(q_c)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];

  // Reference model: raw history of received bits plus a count of bits
  // available for a match (cleared on reset, and on a match when no overlap).
  logic [15:0] hist_m;
  int cnt_a, cnt_b, cnt_c;

  function automatic logic model_q(input logic [15:0] hist, input int cnt,
                                   input logic b, input int w,
                                   input logic [15:0] pat, input logic rst);
    logic [15:0] mask;
    logic [15:0] win;
    mask = (16'h1 << w) - 16'h1;
    win  = ((hist << 1) | {15'b0, b}) & mask;
    return !rst && (cnt + 1 >= w) && (win == (pat & mask));
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one bit (and reset level) for one clock cycle, then score q_o.
  task automatic drive_bit(input logic r, input logic b);
    logic ea, eb, ec;
    logic [2:0] e;
    @(negedge clk_c);
    reset_r = r;
    in_i    = b;
    ea = model_q(hist_m, cnt_a, b, 4, 16'b1011, r);
    eb = model_q(hist_m, cnt_b, b, 4, 16'b1011, r);
    ec = model_q(hist_m, cnt_c, b, 5, 16'b11011, r);
    exp_q.push_back({ea, eb, ec});
    #2;
    e = exp_q.pop_front();
    check_bit($sformatf("a_c%0d", cyc), q_a, e[2]);
    check_bit($sformatf("b_c%0d", cyc), q_b, e[1]);
    check_bit($sformatf("c_c%0d", cyc), q_c, e[0]);
    // model update for the coming edge
    if (r) begin
      hist_m = '0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
    end else begin
      hist_m = (hist_m << 1) | {15'b0, b};
      if (cnt_a < 100) cnt_a++;
      if (cnt_c < 100) cnt_c++;
      if (eb) cnt_b = 0;
      else if (cnt_b < 100) cnt_b++;
    end
    cyc++;
  endtask

  task automatic drive_seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(1'b0, bits[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_r = 1'b1;
    in_i    = 1'b0;
    hist_m  = '0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;

    // basic 1011 then drop to 0
    drive_bit(1'b1, 1'b0);
    drive_seq(16'b10110, 5);

    // overlap / no-overlap stream, then a second 1011
    drive_bit(1'b1, 1'b0);
    drive_seq(16'b1011011, 7);
    drive_seq(16'b1011, 4);

    // 10111011 back-to-back
    drive_bit(1'b1, 1'b0);
    drive_seq(16'b10111011, 8);

    // near misses
    drive_bit(1'b1, 1'b0);
    drive_seq(16'b10011101011, 11);

    // reset mid-pattern with in_i=1 during reset
    drive_bit(1'b1, 1'b0);
    drive_seq(16'b101, 3);
    drive_bit(1'b1, 1'b1);
    drive_seq(16'b1011, 4);

    // 5-bit pattern stream
    drive_bit(1'b1, 1'b0);
    drive_seq(16'b11011011, 8);

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      drive_bit(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
